// File: rtl/chain_pkg.sv
// Shared types and defaults for the chaining front end.
// The tag struct is sized for the widest supported index/offset; users truncate.
package chain_pkg;

    localparam int unsigned WINDOW_DEF    = 64;
    localparam int unsigned SCORE_LAT_DEF = 16;
    localparam int unsigned TAG_I_W       = 32;
    localparam int unsigned TAG_DJ_W      = 16;

    typedef struct packed {
        logic                valid;
        logic [TAG_I_W-1:0]  i;
        logic [TAG_DJ_W-1:0] dj;
        logic                is_end;
        logic                nopair;
    } pair_tag_t;

    typedef enum logic {
        StIdle,
        StIssue
    } state_e;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-latency shift register for pair tags, with synchronous clear so a reset
// flushes every in-flight tag.
module tag_delay_line
    import chain_pkg::*;
#(
    parameter int unsigned DEPTH = SCORE_LAT_DEF,
    parameter type         T     = pair_tag_t
) (
    input  logic clk,
    input  logic clr,
    input  T     in_tag,
    output T     out_tag
);

    T stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= in_tag;
            for (int s = 1; s < DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign out_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/anchor_pair_issuer.sv
// Issues (current, predecessor) anchor pairs to the score pipeline, one per cycle,
// with a tag stream delayed to line up with the pipeline result.
module anchor_pair_issuer
    import chain_pkg::*;
#(
    parameter int unsigned WINDOW    = WINDOW_DEF,
    parameter int unsigned SCORE_LAT = SCORE_LAT_DEF,
    parameter int unsigned IDX_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_r,
    input  logic [31:0]              in_q,
    input  logic                     in_last,
    input  logic [31:0]              cfg_max_dist,
    output logic                     pair_valid,
    output logic [31:0]              riX,
    output logic [31:0]              riY,
    output logic [31:0]              qiX,
    output logic [31:0]              qiY,
    output logic                     tag_valid,
    output logic [IDX_W-1:0]         tag_i,
    output logic [$clog2(WINDOW):0]  tag_dj,
    output logic                     tag_end,
    output logic                     tag_nopair
);

    localparam int unsigned PTR_W = $clog2(WINDOW);
    localparam int unsigned DJ_W  = PTR_W + 1;

    state_e            state_q, state_d;
    logic [31:0]       buf_r_q [WINDOW];
    logic [31:0]       buf_q_q [WINDOW];
    logic              buf_we;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DJ_W-1:0]   count_q, count_d;
    logic [DJ_W-1:0]   k_q, k_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       cur_r_q, cur_r_d, cur_q_q, cur_q_d;
    logic              cur_last_q, cur_last_d;
    logic              end_q, end_d;
    logic              pair_valid_q, pair_valid_d;
    logic [31:0]       rix_q, rix_d, riy_q, riy_d, qix_q, qix_d, qiy_q, qiy_d;
    pair_tag_t         tag_q, tag_d, tag_out;

    logic [DJ_W-1:0]   kk;
    logic [PTR_W-1:0]  slot_a, slot_b;
    logic [31:0]       base_r, base_q;
    logic              elig_a, elig_b, accept, beat_go;

    // Candidate kk is presented next cycle; kk+1 decides whether that beat ends the anchor.
    always_comb begin
        accept = (state_q == StIdle) && in_valid;
        kk     = (state_q == StIdle) ? DJ_W'(1) : k_q + DJ_W'(1);
        base_r = (state_q == StIdle) ? in_r : cur_r_q;
        base_q = (state_q == StIdle) ? in_q : cur_q_q;
        slot_a = wr_ptr_q - kk[PTR_W-1:0];
        slot_b = slot_a - PTR_W'(1);
        elig_a = (kk <= count_q) && ((base_r - buf_r_q[slot_a]) <= cfg_max_dist);
        elig_b = (kk < count_q) && ((base_r - buf_r_q[slot_b]) <= cfg_max_dist);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StIssue;
            StIssue: if (end_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign in_ready = (state_q == StIdle) && !reset;

    always_comb begin
        pair_valid_d = 1'b0;
        rix_d        = rix_q;
        riy_d        = riy_q;
        qix_d        = qix_q;
        qiy_d        = qiy_q;
        tag_d        = '0;
        k_d          = k_q;
        end_d        = end_q;
        cur_r_d      = cur_r_q;
        cur_q_d      = cur_q_q;
        cur_last_d   = cur_last_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        idx_d        = idx_q;
        buf_we       = 1'b0;
        beat_go      = accept || ((state_q == StIssue) && !end_q);

        if (accept) begin
            cur_r_d    = in_r;
            cur_q_d    = in_q;
            cur_last_d = in_last;
        end

        if (beat_go) begin
            pair_valid_d = 1'b1;
            rix_d        = base_r;
            qix_d        = base_q;
            k_d          = kk;
            tag_d.valid  = 1'b1;
            tag_d.i      = TAG_I_W'(idx_q);
            if (elig_a) begin
                riy_d        = buf_r_q[slot_a];
                qiy_d        = buf_q_q[slot_a];
                tag_d.dj     = TAG_DJ_W'(kk);
                tag_d.is_end = !elig_b;
                end_d        = !elig_b;
            end else begin
                riy_d        = base_r;
                qiy_d        = base_q;
                tag_d.is_end = 1'b1;
                tag_d.nopair = 1'b1;
                end_d        = 1'b1;
            end
        end

        if ((state_q == StIssue) && end_q) begin
            buf_we = 1'b1;
            if (cur_last_q) begin
                wr_ptr_d = '0;
                count_d  = '0;
                idx_d    = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = (count_q == DJ_W'(WINDOW)) ? count_q : count_q + DJ_W'(1);
                idx_d    = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            count_q      <= '0;
            k_q          <= '0;
            idx_q        <= '0;
            cur_r_q      <= '0;
            cur_q_q      <= '0;
            cur_last_q   <= 1'b0;
            end_q        <= 1'b0;
            pair_valid_q <= 1'b0;
            rix_q        <= '0;
            riy_q        <= '0;
            qix_q        <= '0;
            qiy_q        <= '0;
            tag_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            k_q          <= k_d;
            idx_q        <= idx_d;
            cur_r_q      <= cur_r_d;
            cur_q_q      <= cur_q_d;
            cur_last_q   <= cur_last_d;
            end_q        <= end_d;
            pair_valid_q <= pair_valid_d;
            rix_q        <= rix_d;
            riy_q        <= riy_d;
            qix_q        <= qix_d;
            qiy_q        <= qiy_d;
            tag_q        <= tag_d;
        end
    end

    // Contents need no reset: count masks every slot not yet written.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_r_q[wr_ptr_q] <= cur_r_q;
            buf_q_q[wr_ptr_q] <= cur_q_q;
        end
    end

    tag_delay_line #(
        .DEPTH (SCORE_LAT),
        .T     (pair_tag_t)
    ) u_tag_delay (
        .clk     (clk),
        .clr     (reset),
        .in_tag  (tag_q),
        .out_tag (tag_out)
    );

    assign pair_valid = pair_valid_q;
    assign riX        = rix_q;
    assign riY        = riy_q;
    assign qiX        = qix_q;
    assign qiY        = qiy_q;
    assign tag_valid  = tag_out.valid;
    assign tag_i      = tag_out.i[IDX_W-1:0];
    assign tag_dj     = tag_out.dj[DJ_W-1:0];
    assign tag_end    = tag_out.is_end;
    assign tag_nopair = tag_out.nopair;

    logic unused_tag_bits;
    assign unused_tag_bits = ^{tag_out.i, tag_out.dj};

endmodule

// File: tb/tb_anchor_pair_issuer.sv
// Bench for anchor_pair_issuer: directed scenarios plus randomized reads, checked
// against a queue-based model of the predecessor window and a tag scoreboard.
module tb_anchor_pair_issuer;

    localparam int WIN = 4;
    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_r = '0;
    logic [31:0] in_q = '0;
    logic        in_last = 1'b0;
    logic [31:0] cfg_max_dist = '0;
    logic        pair_valid;
    logic [31:0] riX, riY, qiX, qiY;
    logic        tag_valid;
    logic [15:0] tag_i;
    logic [2:0]  tag_dj;
    logic        tag_end;
    logic        tag_nopair;

    anchor_pair_issuer #(
        .WINDOW    (WIN),
        .SCORE_LAT (LAT),
        .IDX_W     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_r         (in_r),
        .in_q         (in_q),
        .in_last      (in_last),
        .cfg_max_dist (cfg_max_dist),
        .pair_valid   (pair_valid),
        .riX          (riX),
        .riY          (riY),
        .qiX          (qiX),
        .qiY          (qiY),
        .tag_valid    (tag_valid),
        .tag_i        (tag_i),
        .tag_dj       (tag_dj),
        .tag_end      (tag_end),
        .tag_nopair   (tag_nopair)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int cyc;
        int i;
        int dj;
        bit e;
        bit np;
    } tag_rec_t;

    typedef struct {
        logic [31:0] r;
        logic [31:0] q;
    } anc_t;

    tag_rec_t exp_tags[$];
    tag_rec_t obs_tags[$];
    anc_t     win[$];  // front = most recent stored anchor
    int       m_idx = 0;

    always @(negedge clk) begin
        if (tag_valid === 1'b1)
            obs_tags.push_back('{cyc, int'(tag_i), int'(tag_dj), tag_end, tag_nopair});
    end

    task automatic model_reset();
        win.delete();
        m_idx = 0;
        exp_tags.delete();
        obs_tags.delete();
    endtask

    task automatic send_anchor(input logic [31:0] r, input logic [31:0] q, input bit last);
        int          n;
        int          nb;
        int          waitc;
        logic [31:0] ey;
        logic [31:0] eqy;
        anc_t        a;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_r     = r;
        in_q     = q;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_r     = $urandom;
        in_q     = $urandom;
        in_last  = 1'($urandom);
        n = 0;
        for (int k = 0; k < win.size(); k++) begin
            if (r - win[k].r <= cfg_max_dist) n++;
            else break;
        end
        nb = (n == 0) ? 1 : n;
        for (int j = 1; j <= nb; j++) begin
            ey  = (n != 0) ? win[j-1].r : r;
            eqy = (n != 0) ? win[j-1].q : q;
            n_checks++;
            if (pair_valid !== 1'b1 || riX !== r || qiX !== q || riY !== ey || qiY !== eqy) begin
                n_fail++;
                $display("FAIL beat idx=%0d j=%0d: got v=%b riX=%0d qiX=%0d riY=%0d qiY=%0d required v=1 riX=%0d qiX=%0d riY=%0d qiY=%0d",
                         m_idx, j, pair_valid, riX, qiX, riY, qiY, r, q, ey, eqy);
            end
            exp_tags.push_back('{cyc + LAT, m_idx, (n != 0) ? j : 0, j == nb, n == 0});
            @(negedge clk);
        end
        n_checks++;
        if (pair_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_beats idx=%0d: pair_valid=%b in_ready=%b required 0/1",
                     m_idx, pair_valid, in_ready);
        end
        if (last) begin
            win.delete();
            m_idx = 0;
        end else begin
            a.r = r;
            a.q = q;
            win.push_front(a);
            if (win.size() > WIN) void'(win.pop_back());
            m_idx = (m_idx + 1) % 65536;
        end
    endtask

    task automatic drain_tags(input string name);
        int nmin;
        repeat (LAT + 2) @(negedge clk);
        n_checks++;
        if (obs_tags.size() != exp_tags.size()) begin
            n_fail++;
            $display("FAIL %s tag_count: got %0d required %0d", name, obs_tags.size(),
                     exp_tags.size());
        end
        nmin = (obs_tags.size() < exp_tags.size()) ? obs_tags.size() : exp_tags.size();
        for (int t = 0; t < nmin; t++) begin
            n_checks++;
            if (obs_tags[t] != exp_tags[t]) begin
                n_fail++;
                $display("FAIL %s tag[%0d]: got cyc=%0d i=%0d dj=%0d end=%0d np=%0d required cyc=%0d i=%0d dj=%0d end=%0d np=%0d",
                         name, t, obs_tags[t].cyc, obs_tags[t].i, obs_tags[t].dj,
                         obs_tags[t].e, obs_tags[t].np, exp_tags[t].cyc, exp_tags[t].i,
                         exp_tags[t].dj, exp_tags[t].e, exp_tags[t].np);
            end
        end
        obs_tags.delete();
        exp_tags.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        n_checks++;
        if (pair_valid !== 1'b0 || riX !== 0 || riY !== 0 || qiX !== 0 || qiY !== 0 ||
            tag_valid !== 1'b0 || tag_i !== 0 || tag_dj !== 0 || tag_end !== 1'b0 ||
            tag_nopair !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: pv=%b riX=%0d riY=%0d tv=%b i=%0d dj=%0d required all 0",
                     pair_valid, riX, riY, tag_valid, tag_i, tag_dj);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_in_ready: got %b required 1", in_ready);
        end
        model_reset();
    endtask

    task automatic test_single();
        cfg_max_dist = 32'd1000;
        send_anchor(32'd100, 32'd50, 1'b1);
        drain_tags("single");
    endtask

    task automatic test_three();
        cfg_max_dist = 32'd1000;
        send_anchor(32'd100, 32'd10, 1'b0);
        send_anchor(32'd200, 32'd20, 1'b0);
        send_anchor(32'd300, 32'd30, 1'b1);
        drain_tags("three");
    endtask

    task automatic test_max_dist();
        cfg_max_dist = 32'd150;
        send_anchor(32'd0, 32'd1, 1'b0);
        send_anchor(32'd100, 32'd2, 1'b0);
        send_anchor(32'd200, 32'd3, 1'b0);
        send_anchor(32'd300, 32'd4, 1'b1);
        drain_tags("max_dist");
    endtask

    task automatic test_wrap();
        cfg_max_dist = 32'd1000;
        for (int a = 0; a < 6; a++) send_anchor(32'(a), 32'(a + 40), a == 5);
        drain_tags("wrap");
    endtask

    task automatic test_last_restart();
        cfg_max_dist = 32'd1000;
        send_anchor(32'd5, 32'd1, 1'b0);
        send_anchor(32'd6, 32'd2, 1'b1);
        send_anchor(32'd7, 32'd3, 1'b1);
        drain_tags("last_restart");
    endtask

    task automatic test_reset_mid_issue();
        cfg_max_dist = 32'd1000;
        for (int a = 0; a < 4; a++) send_anchor(32'(a), 32'(a + 90), 1'b0);
        drain_tags("pre_reset");
        in_valid = 1'b1;
        in_r     = 32'd4;
        in_q     = 32'd94;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (pair_valid !== 1'b1 || riY !== 32'd3) begin
            n_fail++;
            $display("FAIL mid_beat1: pv=%b riY=%0d required 1/3", pair_valid, riY);
        end
        @(negedge clk);
        n_checks++;
        if (pair_valid !== 1'b1 || riY !== 32'd2) begin
            n_fail++;
            $display("FAIL mid_beat2: pv=%b riY=%0d required 1/2", pair_valid, riY);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (pair_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_pv: got %b required 0", pair_valid);
        end
        obs_tags.delete();
        exp_tags.delete();
        repeat (LAT + 2) @(negedge clk);
        n_checks++;
        if (obs_tags.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reset_flush: got %0d stale tags required 0", obs_tags.size());
        end
        model_reset();
        send_anchor(32'd7, 32'd70, 1'b1);
        drain_tags("post_mid_reset");
    endtask

    task automatic test_random();
        int          len;
        logic [31:0] r;
        for (int rd = 0; rd < 6; rd++) begin
            cfg_max_dist = $urandom_range(0, 400);
            len          = $urandom_range(1, 10);
            r            = $urandom_range(0, 1000);
            for (int a = 0; a < len; a++) begin
                if ($urandom_range(0, 9) == 0) r = r - 32'($urandom_range(1, 50));
                else r = r + 32'($urandom_range(0, 300));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_anchor(r, $urandom, a == len - 1);
            end
            drain_tags("random");
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_three();
        test_max_dist();
        test_wrap();
        test_last_restart();
        test_reset_mid_issue();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
